// File: rtl/axis_sweep_controller.sv
// Steps a mesh traffic harness through a programmable load table: reset, release, start,
// run to completion or timeout, drain, report. Define AXIS_SWEEP_CYCLES_EN to report RUN duration.
module axis_sweep_controller #(
    parameter int NUM_ROUTERS   = 4,
    parameter int COUNT_WIDTH   = 32,
    parameter int LOAD_WIDTH    = 16,
    parameter int MAX_LOADS     = 16,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int RESET_CYCLES  = 7,
    parameter int START_DELAY   = 5,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               go,
    input  logic                               abort,
    input  logic [$clog2(MAX_LOADS):0]         cfg_num_loads,
    input  logic [TIMEOUT_WIDTH-1:0]           cfg_timeout,
    input  logic                               cfg_wr_en,
    input  logic [$clog2(MAX_LOADS)-1:0]       cfg_wr_addr,
    input  logic [LOAD_WIDTH-1:0]              cfg_wr_data,
    output logic                               harness_rst_n,
    output logic [LOAD_WIDTH-1:0]              load,
    output logic [NUM_ROUTERS-1:0]             start,
    input  logic [NUM_ROUTERS-1:0]             done,
    input  logic [NUM_ROUTERS-1:0]             error,
    input  logic [NUM_ROUTERS*COUNT_WIDTH-1:0] total_sent,
    input  logic [NUM_ROUTERS*COUNT_WIDTH-1:0] total_recv,
    output logic                               busy,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [$clog2(MAX_LOADS)-1:0]       result_idx,
    output logic                               result_timeout,
    output logic                               result_error,
    output logic [TIMEOUT_WIDTH-1:0]           result_cycles,
    output logic                               sweep_finished
);

    localparam int IDX_W = $clog2(MAX_LOADS);
    localparam int NL_W  = IDX_W + 1;
    localparam int SUM_W = COUNT_WIDTH + $clog2(NUM_ROUTERS);
    localparam int PH_W  = 16;
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0] DELAY_LAST = PH_W'(START_DELAY - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RST_HOLD, RELEASE, RUN, DRAIN, REPORT} state_t;

    state_t                   state, state_next;
    logic [PH_W-1:0]          phase_cnt;
    logic [IDX_W-1:0]         idx, idx_next;
    logic [NL_W-1:0]          num_loads_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [NUM_ROUTERS-1:0]   done_seen;
    logic                     err_acc;
    logic [TIMEOUT_WIDTH-1:0] run_cnt, run_cnt_inc;
    logic                     timed_out;
    logic [SUM_W-1:0]         sum_sent, sum_recv;
    logic                     go_ok, complete, timeout_hit, last_point, handshake;
    logic                     enter_hold, enter_run, enter_report;
    logic [LOAD_WIDTH-1:0]    load_tbl [MAX_LOADS];

    // Table contents survive reset; only IDLE may rewrite them.
    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_wr_en)
            load_tbl[cfg_wr_addr] <= cfg_wr_data;
    end

    always_comb begin
        sum_sent = '0;
        sum_recv = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            sum_sent = sum_sent + SUM_W'(total_sent[i*COUNT_WIDTH +: COUNT_WIDTH]);
            sum_recv = sum_recv + SUM_W'(total_recv[i*COUNT_WIDTH +: COUNT_WIDTH]);
        end
    end

    assign go_ok       = (cfg_num_loads != '0) && (cfg_num_loads <= NL_W'(MAX_LOADS));
    assign complete    = (&(done_seen | done)) && (sum_sent == sum_recv);
    assign run_cnt_inc = (&run_cnt) ? run_cnt : run_cnt + TIMEOUT_WIDTH'(1);
    // The counter value after this cycle's increment is the number of RUN cycles elapsed.
    assign timeout_hit = (timeout_q != '0) && (run_cnt_inc == timeout_q);
    assign last_point  = ({1'b0, idx} == num_loads_q - NL_W'(1));
    assign handshake   = result_valid && result_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE:     if (go && go_ok) begin
                          state_next = RST_HOLD;
                          idx_next   = '0;
                      end
            RST_HOLD: if (phase_cnt == HOLD_LAST) state_next = RELEASE;
            RELEASE:  if (phase_cnt == DELAY_LAST) state_next = RUN;
            RUN:      if (complete || timeout_hit) state_next = DRAIN;
            DRAIN:    if (phase_cnt == DRAIN_LAST) state_next = REPORT;
            REPORT:   if (handshake) begin
                          if (last_point) begin
                              state_next = IDLE;
                          end else begin
                              state_next = RST_HOLD;
                              idx_next   = idx + IDX_W'(1);
                          end
                      end
            default:  state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            idx_next   = idx;
        end
    end

    assign enter_hold   = (state_next == RST_HOLD) && (state != RST_HOLD);
    assign enter_run    = (state_next == RUN) && (state != RUN);
    assign enter_report = (state_next == REPORT) && (state != REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt      <= '0;
            idx            <= '0;
            num_loads_q    <= '0;
            timeout_q      <= '0;
            done_seen      <= '0;
            err_acc        <= 1'b0;
            run_cnt        <= '0;
            timed_out      <= 1'b0;
            harness_rst_n  <= 1'b0;
            load           <= '0;
            start          <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_idx     <= '0;
            result_timeout <= 1'b0;
            result_error   <= 1'b0;
            sweep_finished <= 1'b0;
        end else begin
            phase_cnt      <= (state_next != state) ? '0 : phase_cnt + PH_W'(1);
            idx            <= idx_next;
            busy           <= (state_next != IDLE);
            harness_rst_n  <= (state_next != IDLE) && (state_next != RST_HOLD);
            result_valid   <= (state_next == REPORT);
            sweep_finished <= (state == REPORT) && handshake && last_point && !abort;

            if (state == IDLE && state_next == RST_HOLD) begin
                num_loads_q <= cfg_num_loads;
                timeout_q   <= cfg_timeout;
            end
            if (enter_hold)
                load <= load_tbl[idx_next];

            if (enter_run) begin
                start     <= '1;
                done_seen <= '0;
                err_acc   <= 1'b0;
                run_cnt   <= '0;
            end else if (state == RUN) begin
                start     <= start & ~done;
                done_seen <= done_seen | done;
                err_acc   <= err_acc | (|error);
                run_cnt   <= run_cnt_inc;
                if (state_next == DRAIN)
                    timed_out <= !complete;
            end else if (state == DRAIN) begin
                err_acc <= err_acc | (|error);
            end
            if (state_next != RUN)
                start <= '0;

            if (enter_report) begin
                result_idx     <= idx;
                result_timeout <= timed_out;
                result_error   <= err_acc | (|error);
            end
        end
    end

`ifdef AXIS_SWEEP_CYCLES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            result_cycles <= '0;
        else if (enter_report) result_cycles <= run_cnt;
    end
`else
    assign result_cycles = '0;
`endif

endmodule

// File: tb/tb_axis_sweep_controller.sv
// Scoreboard bench for axis_sweep_controller: a behavioural harness drives done/error/totals,
// expected result records are queued by the stimulus and checked by a monitor on the handshake.
module tb_axis_sweep_controller;

    localparam int NR = 4;
    localparam int CW = 32;
    localparam int LW = 16;
    localparam int ML = 16;
    localparam int TW = 32;
    localparam int IW = $clog2(ML);
    localparam int NLW = IW + 1;
    localparam int RESET_CYCLES = 7;
    localparam int START_DELAY = 5;
    localparam int DRAIN_CYCLES = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go, abort;
    logic [NLW-1:0]    cfg_num_loads;
    logic [TW-1:0]     cfg_timeout;
    logic              cfg_wr_en;
    logic [IW-1:0]     cfg_wr_addr;
    logic [LW-1:0]     cfg_wr_data;
    logic              harness_rst_n;
    logic [LW-1:0]     load;
    logic [NR-1:0]     start;
    logic [NR-1:0]     done;
    logic [NR-1:0]     error;
    logic [NR*CW-1:0]  total_sent;
    logic [NR*CW-1:0]  total_recv;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [IW-1:0]     result_idx;
    logic              result_timeout;
    logic              result_error;
    logic [TW-1:0]     result_cycles;
    logic              sweep_finished;

    axis_sweep_controller dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .cfg_num_loads(cfg_num_loads), .cfg_timeout(cfg_timeout),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .harness_rst_n(harness_rst_n), .load(load), .start(start),
        .done(done), .error(error), .total_sent(total_sent), .total_recv(total_recv),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_idx(result_idx), .result_timeout(result_timeout),
        .result_error(result_error), .result_cycles(result_cycles),
        .sweep_finished(sweep_finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int to;
        int err;
        int cyc;
        int last;
        int lat;
    } rec_t;

    rec_t exp_q[$];
    int   load_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   sf_count = 0;

    // Harness behaviour knobs (RUN cycle numbers, 1-based; 0 = never)
    int done_at [NR];
    int match_at = 0;
    int err_at = 0;
    int ready_hold = 0;
    int run_cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input int i, input int to, input int er, input int cyc, input int last);
        rec_t r;
        r.idx = i; r.to = to; r.err = er; r.cyc = cyc; r.last = last;
        r.lat = cyc + DRAIN_CYCLES + 1;
        exp_q.push_back(r);
    endtask

    task automatic wr_table(input int a, input int d);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = IW'(a);
        cfg_wr_data = LW'(d);
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_go(input int nl, input int to);
        cfg_num_loads = NLW'(nl);
        cfg_timeout = TW'(to);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic set_harness(input int d0, input int d1, input int d2, input int d3,
                               input int m, input int e, input int h);
        done_at[0] = d0; done_at[1] = d1; done_at[2] = d2; done_at[3] = d3;
        match_at = m; err_at = e; ready_hold = h;
    endtask

    task automatic wait_finish(input string nm, input int exp_sf);
        for (int i = 0; i < 2000 && sf_count < exp_sf; i++) tick();
        chk({nm, "_finish_count"}, sf_count, exp_sf);
        chk({nm, "_results_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({nm, "_idle_after"}, busy, 0);
        tick();
    endtask

    task automatic wait_run(input string nm, input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (run_cyc != k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (run_cyc != k) note_fail({nm, "_run_wait_expired"});
    endtask

    // Behavioural harness and result consumer, updated just after each active edge.
    initial begin
        logic [NR-1:0] prev_start;
        int vcnt;
        prev_start = '0;
        vcnt = 0;
        done = '0;
        error = '0;
        result_ready = 1'b0;
        total_sent = '0;
        total_recv = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!harness_rst_n) run_cyc = 0;
            else if (run_cyc == 0 && start == '1 && prev_start == '0) run_cyc = 1;
            else if (run_cyc != 0) run_cyc++;
            prev_start = start;
            for (int i = 0; i < NR; i++) begin
                done[i] = (run_cyc != 0) && (done_at[i] != 0) && (run_cyc >= done_at[i]);
                total_sent[i*CW +: CW] = CW'(1000 + 37 * i);
                total_recv[i*CW +: CW] = CW'(1000 + 37 * i - ((i == 0 && run_cyc < match_at) ? 1 : 0));
            end
            error = (run_cyc != 0 && run_cyc == err_at) ? 4'b0100 : 4'b0000;
            if (result_valid) begin
                vcnt++;
                result_ready = (vcnt > ready_hold);
            end else begin
                vcnt = 0;
                result_ready = 1'b0;
            end
        end
    end

    // Monitor: sequencing timeline, result scoreboard and sweep_finished, sampled mid-cycle.
    initial begin
        int low_cnt, rel_cnt;
        bit rel_armed, prev_valid, prev_hs, prev_hrst, expect_sf, hs;
        logic [IW-1:0] s_idx;
        logic s_to, s_err;
        logic [TW-1:0] s_cyc;
        rec_t r;
        int exp_cyc;
        low_cnt = 0; rel_cnt = 0; rel_armed = 0;
        prev_valid = 0; prev_hs = 0; prev_hrst = 0; expect_sf = 0;
        s_idx = '0; s_to = 0; s_err = 0; s_cyc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low_cnt = 0; rel_armed = 0; prev_valid = 0; prev_hs = 0;
                prev_hrst = 0; expect_sf = 0;
            end else begin
                if (busy && !harness_rst_n) low_cnt++;
                else if (!busy) low_cnt = 0;
                if (!harness_rst_n) rel_armed = 0;
                if (harness_rst_n && !prev_hrst && busy) begin
                    chk("rst_hold_len", low_cnt, RESET_CYCLES);
                    if (load_q.size() == 0) note_fail("load_unexpected_point");
                    else chk("load_value", load, load_q.pop_front());
                    low_cnt = 0;
                    rel_armed = 1;
                    rel_cnt = 0;
                end
                if (rel_armed) begin
                    if (start == '0) rel_cnt++;
                    else begin
                        chk("start_delay", rel_cnt, START_DELAY);
                        chk("start_all_ones", start, 4'hF);
                        rel_armed = 0;
                    end
                end
                if (prev_hs) chk("valid_drop_after_hs", result_valid, 0);
                if (result_valid && !prev_valid) begin
                    if (exp_q.size() == 0) note_fail("result_unexpected");
                    else chk("result_latency", run_cyc, exp_q[0].lat);
                end
                if (result_valid && prev_valid && !prev_hs) begin
                    chk("hold_idx", result_idx, s_idx);
                    chk("hold_timeout", result_timeout, s_to);
                    chk("hold_error", result_error, s_err);
                    chk("hold_cycles", result_cycles, s_cyc);
                    chk("hold_no_restart", harness_rst_n, 1);
                end
                if (sweep_finished || expect_sf) chk("sweep_finished", sweep_finished, expect_sf);
                if (sweep_finished) sf_count++;
                expect_sf = 0;
                hs = result_valid && result_ready;
                if (hs) begin
                    if (exp_q.size() == 0) note_fail("result_handshake_unexpected");
                    else begin
                        r = exp_q.pop_front();
`ifdef AXIS_SWEEP_CYCLES_EN
                        exp_cyc = r.cyc;
`else
                        exp_cyc = 0;
`endif
                        chk("result_idx", result_idx, r.idx);
                        chk("result_timeout", result_timeout, r.to);
                        chk("result_error", result_error, r.err);
                        chk("result_cycles", result_cycles, exp_cyc);
                        if (r.last != 0) expect_sf = 1;
                    end
                end
                s_idx = result_idx; s_to = result_timeout; s_err = result_error; s_cyc = result_cycles;
                prev_valid = result_valid;
                prev_hs = hs;
                prev_hrst = harness_rst_n;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sf_before;
        logic [NR-1:0] exp_start;
        rst_n = 1'b0;
        go = 1'b0; abort = 1'b0;
        cfg_num_loads = '0; cfg_timeout = '0;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        set_harness(50, 50, 50, 50, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_harness_rst_n", harness_rst_n, 0);
        chk("rst_load", load, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_idx", result_idx, 0);
        chk("rst_result_timeout", result_timeout, 0);
        chk("rst_result_error", result_error, 0);
        chk("rst_result_cycles", result_cycles, 0);
        chk("rst_sweep_finished", sweep_finished, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Normal two-point sweep; a table write while busy must be ignored.
        wr_table(0, 'h0290);
        wr_table(1, 'h1999);
        load_q.push_back('h0290);
        load_q.push_back('h1999);
        push_rec(0, 0, 0, 50, 0);
        push_rec(1, 0, 0, 50, 1);
        do_go(2, 0);
        repeat (20) tick();
        wr_table(0, 'hBEEF);
        wait_finish("normal", 1);

        // Timeout with done never asserted; table[0] must still hold the original value.
        set_harness(0, 0, 0, 0, 0, 0, 0);
        load_q.push_back('h0290);
        push_rec(0, 1, 0, 100, 1);
        do_go(1, 100);
        wait_finish("timeout", 2);

        // Done staggered by cycle 10, totals equal only from cycle 30.
        set_harness(7, 8, 9, 10, 30, 0, 0);
        load_q.push_back('h0290);
        push_rec(0, 0, 0, 30, 1);
        do_go(1, 0);
        wait_run("mismatch", 1);
        for (int k = 1; k <= 30; k++) begin
            for (int i = 0; i < NR; i++) exp_start[i] = (k <= done_at[i]);
            chk("per_router_start", start, exp_start);
            @(negedge clk);
        end
        wait_finish("mismatch", 3);

        // Completion and timeout in the same cycle: completion wins.
        set_harness(50, 50, 50, 50, 0, 0, 0);
        load_q.push_back('h0290);
        push_rec(0, 0, 0, 50, 1);
        do_go(1, 50);
        wait_finish("tie", 4);

        // Error pulse during DRAIN plus 20 cycles of backpressure on each of two points.
        set_harness(50, 50, 50, 50, 0, 52, 20);
        load_q.push_back('h0290);
        load_q.push_back('h1999);
        push_rec(0, 0, 1, 50, 0);
        push_rec(1, 0, 1, 50, 1);
        do_go(2, 0);
        wait_finish("err_bp", 5);

        // Abort mid-RUN, then abort together with go, then a clean restart at idx 0.
        set_harness(50, 50, 50, 50, 0, 0, 0);
        sf_before = sf_count;
        load_q.push_back('h0290);
        do_go(2, 0);
        wait_run("abort", 20);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_start", start, 0);
        chk("abort_harness_rst_n", harness_rst_n, 0);
        chk("abort_result_valid", result_valid, 0);
        tick();
        cfg_num_loads = NLW'(1);
        go = 1'b1;
        abort = 1'b1;
        tick();
        go = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_beats_go", busy, 0);
        repeat (10) tick();
        chk("abort_no_finish", sf_count, sf_before);
        chk("abort_loads_consumed", load_q.size(), 0);
        load_q.push_back('h0290);
        push_rec(0, 0, 0, 50, 1);
        do_go(1, 0);
        wait_finish("restart", sf_before + 1);

        // Config guards on go.
        do_go(0, 0);
        @(negedge clk);
        chk("go_zero_loads", busy, 0);
        tick();
        do_go(17, 0);
        @(negedge clk);
        chk("go_too_many_loads", busy, 0);
        tick();

        // Asynchronous reset in the middle of RUN.
        load_q.push_back('h0290);
        do_go(1, 0);
        wait_run("async_rst", 10);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", start, 0);
        chk("arst_harness_rst_n", harness_rst_n, 0);
        chk("arst_load", load, 0);
        chk("arst_result_valid", result_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
